// File: rtl/pattern_launch_chk.sv
// pattern_launch_chk: launches a toggle/PRBS7 bit stream and checks the returned capture LAT cycles later.
// Optional feature macro: PLC_X_DETECT_EN counts X/Z captures in x_cnt instead of err_cnt (simulation-only check).
module pattern_launch_chk #(
    parameter int         BURST_W = 8,
    parameter int         LAT     = 2,
    parameter logic [6:0] SEED    = 7'h7F
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               mode,
    input  logic [BURST_W-1:0] burst_len,
    output logic               tx_d,
    input  logic               rx_q,
    output logic               busy,
    output logic               done,
    output logic [BURST_W-1:0] err_cnt,
    output logic [BURST_W-1:0] x_cnt
);

    if (SEED == 7'd0 || LAT < 1 || LAT > 8) begin : g_param_err
        $error("pattern_launch_chk: SEED must be nonzero and LAT must be 1..8");
    end

    typedef enum logic [1:0] {IDLE, SEND, DRAIN, DONE} state_t;

    localparam logic [LAT-1:0] TAP = LAT'(1) << (LAT - 1);

    state_t             state, state_nxt;
    logic               mode_r;
    logic [BURST_W-1:0] len_r;
    logic [BURST_W-1:0] sent;
    logic [6:0]         lfsr;
    logic [LAT-1:0]     vld;
    logic [LAT-1:0]     pipe;
    logic               launch;
    logic               bit_nxt;
    logic               accept;

    function automatic logic [6:0] prbs_step(input logic [6:0] s);
        return {s[5:0], s[6] ^ s[5]};
    endfunction

    assign accept = (state == IDLE) && start;
    assign busy   = (state == SEND) || (state == DRAIN);
    assign done   = (state == DONE);

    // next state, and which bit (if any) is launched at the coming edge
    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        bit_nxt   = 1'b0;
        case (state)
            IDLE: if (start) begin
                state_nxt = (burst_len == '0) ? DONE : SEND;
                launch    = (burst_len != '0);
                bit_nxt   = mode ? SEED[6] : 1'b1;
            end
            SEND: if (sent == len_r) begin
                state_nxt = (vld == TAP) ? DONE : DRAIN;
            end else begin
                launch  = 1'b1;
                bit_nxt = mode_r ? lfsr[6] : ~tx_d;
            end
            DRAIN: state_nxt = (vld == TAP) ? DONE : DRAIN;
            DONE:  state_nxt = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // launch register, pattern generator and expected-bit pipe (tap LAT-1 lines up with rx_q)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_d   <= 1'b0;
            mode_r <= 1'b0;
            len_r  <= '0;
            sent   <= '0;
            lfsr   <= SEED;
            vld    <= '0;
            pipe   <= '0;
        end else begin
            tx_d <= launch & bit_nxt;
            vld  <= (vld << 1) | LAT'(launch);
            pipe <= (pipe << 1) | LAT'(launch & bit_nxt);
            if (accept) begin
                mode_r <= mode;
                len_r  <= burst_len;
                sent   <= BURST_W'(1);
                lfsr   <= prbs_step(SEED);
            end else if (launch) begin
                sent <= sent + 1'b1;
                lfsr <= prbs_step(lfsr);
            end
        end
    end

`ifdef PLC_X_DETECT_EN
    // compare counters; X/Z captures are tallied separately from real mismatches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
            x_cnt   <= '0;
        end else if (accept) begin
            err_cnt <= '0;
            x_cnt   <= '0;
        end else if (vld[LAT-1]) begin
            if (rx_q === 1'bx || rx_q === 1'bz) x_cnt <= x_cnt + 1'b1;
            else if (rx_q !== pipe[LAT-1])      err_cnt <= err_cnt + 1'b1;
        end
    end
`else
    assign x_cnt = '0;

    // compare counter; a non-0/1 capture is not identical to the expected bit so it counts as an error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                     err_cnt <= '0;
        else if (accept)                                err_cnt <= '0;
        else if (vld[LAT-1] && rx_q !== pipe[LAT-1])    err_cnt <= err_cnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_pattern_launch_chk.sv
// tb_pattern_launch_chk: scoreboard bench for pattern_launch_chk (LAT=2, capture flop loop-back).
module tb_pattern_launch_chk;

    localparam int         BW   = 8;
    localparam int         LAT  = 2;
    localparam logic [6:0] SEED = 7'h7F;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          mode = 1'b0;
    logic [BW-1:0] burst_len = '0;
    logic          tx_d;
    logic          rx_q;
    logic          busy;
    logic          done;
    logic [BW-1:0] err_cnt;
    logic [BW-1:0] x_cnt;

    logic cap;
    logic tie0 = 1'b0;
    logic force_x = 1'b0;
    logic xval;
    bit   four_state;

    int n_cmp = 0;
    int n_err = 0;
    bit exp_q[$];

    pattern_launch_chk #(.BURST_W(BW), .LAT(LAT), .SEED(SEED)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .burst_len(burst_len),
        .tx_d(tx_d), .rx_q(rx_q), .busy(busy), .done(done),
        .err_cnt(err_cnt), .x_cnt(x_cnt)
    );

    always #5 clk = ~clk;

    // capture flop of the path under test: with the launch flop this gives LAT=2
    always @(posedge clk) cap <= tx_d;

    always_comb rx_q = force_x ? xval : (tie0 ? 1'b0 : cap);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // one burst: model pushes expected bits, then each cycle pops and compares tx_d/busy/done
    task automatic run_burst(input string tag, input logic m, input int n, input logic t0,
                             input logic [7:0] xmask, input int mid);
        logic [6:0] l = SEED;
        int   e_err = 0;
        int   e_x = 0;
        int   last;
        bit   b;
        logic [7:0] first8 = '0;
        for (int i = 0; i < n; i++) begin
            b = m ? l[6] : (i % 2 == 0);
            l = {l[5:0], l[6] ^ l[5]};
            exp_q.push_back(b);
            if (i < 8 && xmask[i]) begin
                if (four_state) begin
`ifdef PLC_X_DETECT_EN
                    e_x++;
`else
                    e_err++;
`endif
                end else if (xval !== b) e_err++;
            end else if (t0 && b) e_err++;
        end
        last = (n == 0) ? 0 : n + LAT - 1;
        tie0      = t0;
        mode      = m;
        burst_len = BW'(n);
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c <= last; c++) begin
            if (c < n) begin
                b = exp_q.pop_front();
                check({tag, "_tx"}, tx_d, b);
                if (c < 8) first8 = {first8[6:0], tx_d};
            end else begin
                check({tag, "_tx_idle"}, tx_d, 0);
            end
            check({tag, "_done"}, done, (c == last));
            check({tag, "_busy"}, busy, (c < last));
            force_x   = (c >= 1) && (c - 1 < 8) && (c - 1 < n) && xmask[(c-1) % 8];
            start     = (c == mid);
            burst_len = (c == mid) ? '0 : BW'(n);
            @(posedge clk); #1;
        end
        force_x = 1'b0;
        start   = 1'b0;
        check({tag, "_done_end"}, done, 0);
        check({tag, "_err_cnt"}, err_cnt, e_err);
        check({tag, "_x_cnt"}, x_cnt, e_x);
        check({tag, "_queue"}, exp_q.size(), 0);
        if (m && n >= 8) check({tag, "_first8"}, first8, 8'hFE);
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        xval = 1'bx;
        four_state = $isunknown(xval);
        #12;
        check("rst_tx", tx_d, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err_cnt, 0);
        check("rst_x", x_cnt, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_burst("tog8", 1'b0, 8, 1'b0, 8'h00, -1);
        run_burst("prbs127", 1'b1, 127, 1'b0, 8'h00, -1);
        run_burst("tie0", 1'b0, 10, 1'b1, 8'h00, -1);
        run_burst("mid_start", 1'b0, 8, 1'b0, 8'h00, 3);
        run_burst("zero", 1'b0, 0, 1'b0, 8'h00, -1);

        // abort a burst with reset while bit 4 is on tx_d
        tie0 = 1'b1;
        mode = 1'b0;
        burst_len = 8'd8;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("abort_pre_tx", tx_d, 1);
        check("abort_pre_err", err_cnt, 2);
        rst_n = 1'b0;
        #1;
        check("abort_tx", tx_d, 0);
        check("abort_busy", busy, 0);
        check("abort_err", err_cnt, 0);
        check("abort_done", done, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("abort_no_done", done, 0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("abort_idle_done", done, 0);

        run_burst("tog8_again", 1'b0, 8, 1'b0, 8'h00, -1);
        run_burst("xinj", 1'b0, 8, 1'b0, 8'b0001_0101, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
